// File: rtl/fetch_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_stage_pkg
// Brief    : Shared core constants and types for the fetch stage: default
//            reset PC, NOP encoding and the fetch FIFO entry layout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_stage_pkg;

    // First fetch address after reset unless overridden at instantiation
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0 -- what the decode register shows before any fetch lands
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Brief    : Two-entry instruction FIFO between the memory response path and
//            the decode register. Flush empties it in one cycle and wins over
//            push/pop in the same cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q,  count_d;
    logic         w_do_push;
    logic         w_do_pop;

    assign full_o    = (count_q == 2'd2);
    assign empty_o   = (count_q == 2'd0);
    assign head_o    = mem_q[rd_ptr_q];
    assign w_do_push = push_i & ~full_o & ~flush_i;
    assign w_do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next pointers and occupancy; flush resets everything to empty
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_do_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (w_do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module   : fetch_stage
// Brief    : Instruction fetch stage. Issues sequential word fetches under a
//            two-credit scheme, buffers in-order responses in a 2-entry FIFO,
//            feeds the decode pipeline register and handles jump/branch
//            redirects by flushing the FIFO and killing in-flight responses.
// Config   : FETCH_MISALIGN_CHECK_EN - when defined, a redirect to a target
//            with nonzero bits[1:0] raises sticky misaligned_f and stops
//            fetching until reset; otherwise target bits[1:0] are cleared.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halted,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        jump_d,
    input  logic [31:0] pc_imm_d,
    input  logic        branch_e,
    input  logic [31:0] pc_target_e,
    input  logic        stall,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        misaligned_f
);

    logic [31:0]  pc_f_q,        pc_f_d;
    logic [31:0]  resp_pc_q,     resp_pc_d;
    logic [1:0]   outstanding_q, outstanding_d;
    logic [1:0]   kill_q,        kill_d;
    logic [31:0]  dec_instr_q,   dec_instr_d;
    logic [31:0]  dec_pc_q,      dec_pc_d;
    logic         dec_valid_q,   dec_valid_d;

    logic         w_redirect;
    logic [31:0]  w_raw_target;
    logic [31:0]  w_target;
    logic         w_fetch_block;
    logic [1:0]   w_occupancy;
    logic         w_credit;
    logic         w_grant;
    logic         w_rvalid_live;
    logic         w_push;
    logic         w_pop;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    // Branch from execute is older than the jump in decode, so it wins
    assign w_redirect   = branch_e | jump_d;
    assign w_raw_target = branch_e ? pc_target_e : pc_imm_d;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign w_target      = w_raw_target;
    assign w_fetch_block = misaligned_q;
    assign misaligned_f  = misaligned_q;

    // Sticky flag: any redirect to a non-word-aligned target
    always_comb begin
        misaligned_d = misaligned_q | (w_redirect & (w_raw_target[1:0] != 2'b00));
    end

    // Misaligned flag register, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    assign w_target      = w_raw_target & ~32'h0000_0003;
    assign w_fetch_block = 1'b0;
    assign misaligned_f  = 1'b0;
`endif

    // Requests are limited so that every in-flight response has a FIFO slot
    assign w_occupancy   = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
    assign w_credit      = ({1'b0, outstanding_q} + {1'b0, w_occupancy}) < 3'd2;
    assign imem_req      = ~halted & ~w_redirect & ~w_fetch_block & w_credit;
    assign imem_addr     = pc_f_q;
    assign w_grant       = imem_req & imem_gnt;

    // A response with nothing outstanding belongs to a request from before reset
    assign w_rvalid_live = imem_rvalid & (outstanding_q != 2'd0);
    assign w_push        = w_rvalid_live & (kill_q == 2'd0) & ~w_redirect;
    assign w_pop         = ~stall & ~w_fifo_empty & ~w_redirect;

    assign w_push_entry.pc    = resp_pc_q;
    assign w_push_entry.instr = imem_rdata;

    assign instr_d = dec_instr_q;
    assign pc_d    = dec_pc_q;
    assign valid_d = dec_valid_q;

    fetch_fifo u_fetch_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (w_redirect),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    // Fetch PC, response PC tracking, outstanding and kill counters
    always_comb begin
        pc_f_d        = pc_f_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;

        if (w_redirect) begin
            pc_f_d = w_target;
        end else if (w_grant) begin
            pc_f_d = pc_f_q + 32'd4;
        end

        // Responses arrive in order, so the next kept one is the next sequential PC
        if (w_redirect) begin
            resp_pc_d = w_target;
        end else if (w_push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end

        case ({w_grant, w_rvalid_live})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase

        // Everything still in flight at a redirect is stale
        if (w_redirect) begin
            kill_d = w_rvalid_live ? (outstanding_q - 2'd1) : outstanding_q;
        end else if (w_rvalid_live && (kill_q != 2'd0)) begin
            kill_d = kill_q - 2'd1;
        end
    end

    // Decode register: redirect bubbles, stall holds, otherwise load FIFO head
    always_comb begin
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        dec_valid_d = dec_valid_q;
        if (w_redirect) begin
            dec_valid_d = 1'b0;
        end else if (!stall) begin
            if (!w_fifo_empty) begin
                dec_instr_d = w_head.instr;
                dec_pc_d    = w_head.pc;
                dec_valid_d = 1'b1;
            end else begin
                dec_valid_d = 1'b0;
            end
        end
    end

    // Fetch-side state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q        <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= 2'd0;
            kill_q        <= 2'd0;
        end else begin
            pc_f_q        <= pc_f_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    // Decode pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_instr_q <= c_NOP_INSTR;
            dec_pc_q    <= 32'h0000_0000;
            dec_valid_q <= 1'b0;
        end else begin
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_valid_q <= dec_valid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage with a latency-programmable
//            instruction memory responder and an in-order scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        halted;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        jump_d;
    logic [31:0] pc_imm_d;
    logic        branch_e;
    logic [31:0] pc_target_e;
    logic        stall;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        misaligned_f;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int           checks      = 0;
    int           failures    = 0;
    int           cyc         = 0;
    int           lat         = 1;
    int           inject_req  = 0;
    int           inject_done = 0;
    pend_t        pend_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  grant_log[$];

    fetch_stage #(.RESET_PC(c_RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .halted       (halted),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .jump_d       (jump_d),
        .pc_imm_d     (pc_imm_d),
        .branch_e     (branch_e),
        .pc_target_e  (pc_target_e),
        .stall        (stall),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .valid_d      (valid_d),
        .misaligned_f (misaligned_f)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h1357_9BDF;
    endfunction

    // Memory responder: records grants, returns data after 'lat' cycles in order,
    // and keeps the scoreboard of instructions expected at decode.
    initial begin : responder
        pend_t        p;
        fetch_entry_t e;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                pend_q.delete();
                exp_q.delete();
            end else begin
                if (branch_e || jump_d) begin
                    exp_q.delete();
                end
                if (imem_req && imem_gnt) begin
                    p.addr = imem_addr;
                    p.due  = cyc + lat;
                    pend_q.push_back(p);
                    e.pc    = imem_addr;
                    e.instr = mem_word(imem_addr);
                    exp_q.push_back(e);
                    grant_log.push_back(imem_addr);
                end
            end
            #1;
            if (inject_req != inject_done) begin
                inject_done = inject_req;
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (pend_q.size() != 0 && pend_q[0].due <= cyc + 1) begin
                p = pend_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(p.addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Scoreboard consumer: each new decode load must match the oldest expectation
    initial begin : monitor
        logic         st;
        logic         rs;
        fetch_entry_t e;
        forever begin
            @(posedge clk);
            st = stall;
            rs = reset;
            #1;
            if (!rs && !st && valid_d === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_unexpected got pc_d=%h instr_d=%h expected no valid instruction", pc_d, instr_d);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_d !== e.pc || instr_d !== e.instr) begin
                        failures++;
                        $display("FAIL scoreboard_entry got pc_d=%h instr_d=%h expected pc_d=%h instr_d=%h",
                                 pc_d, instr_d, e.pc, e.instr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        halted      = 1'b0;
        stall       = 1'b0;
        jump_d      = 1'b0;
        branch_e    = 1'b0;
        pc_imm_d    = 32'h0;
        pc_target_e = 32'h0;
        imem_gnt    = 1'b0;
        lat         = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (valid_d !== 1'b1 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        halted = 1'b0; stall = 1'b0; jump_d = 1'b0; branch_e = 1'b0;
        pc_imm_d = 32'h0; pc_target_e = 32'h0; imem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", valid_d); end
        checks++; if (instr_d !== c_NOP_INSTR) begin failures++; $display("FAIL reset_instr got %h expected %h", instr_d, c_NOP_INSTR); end
        checks++; if (pc_d !== 32'h0) begin failures++; $display("FAIL reset_pc_d got %h expected 00000000", pc_d); end
        checks++; if (misaligned_f !== 1'b0) begin failures++; $display("FAIL reset_misaligned got %b expected 0", misaligned_f); end
        checks++; if (imem_addr !== c_RESET_PC) begin failures++; $display("FAIL reset_addr got %h expected %h", imem_addr, c_RESET_PC); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_first_req got %b expected 1", imem_req); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        grant_log.delete();
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL b2b_valid_c0 got %b expected 0", valid_d); end
        @(posedge clk); #1;
        checks++; if (valid_d !== 1'b0) begin failures++; $display("FAIL b2b_valid_c1 got %b expected 0", valid_d); end
        @(posedge clk); #1;
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'h0) begin failures++; $display("FAIL b2b_first_valid got valid=%b pc=%h expected valid=1 pc=00000000", valid_d, pc_d); end
        repeat (10) @(negedge clk);
        checks++;
        if (grant_log.size() < 3) begin
            failures++; $display("FAIL b2b_grants got %0d grants expected at least 3", grant_log.size());
        end else if (grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 || grant_log[2] !== 32'h8) begin
            failures++; $display("FAIL b2b_grants got %h %h %h expected 00000000 00000004 00000008", grant_log[0], grant_log[1], grant_log[2]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        int          n;
        do_reset();
        imem_gnt = 1'b1;
        repeat (5) @(negedge clk);
        stall      = 1'b1;
        held_pc    = pc_d;
        held_instr = instr_d;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req cycle %0d got %b expected 0", i, imem_req); end
            checks++; if (pc_d !== held_pc || instr_d !== held_instr) begin failures++; $display("FAIL stall_hold cycle %0d got pc=%h instr=%h expected pc=%h instr=%h", i, pc_d, instr_d, held_pc, held_instr); end
        end
        stall = 1'b0;
        repeat (12) @(negedge clk);
        imem_gnt = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_jump();
        int n;
        do_reset();
        lat      = 3;
        imem_gnt = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        jump_d   = 1'b1;
        pc_imm_d = 32'h100;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL jump_req got %b expected 0", imem_req); end
        @(negedge clk);
        jump_d = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL jump_addr got %h expected 00000100", imem_addr); end
        wait_valid(n);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'h100) begin failures++; $display("FAIL jump_first_pc got valid=%b pc=%h expected valid=1 pc=00000100", valid_d, pc_d); end
    endtask

    task automatic test_branch_jump();
        int n;
        do_reset();
        imem_gnt = 1'b1;
        repeat (3) @(negedge clk);
        branch_e    = 1'b1;
        pc_target_e = 32'h200;
        jump_d      = 1'b1;
        pc_imm_d    = 32'h300;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bj_req got %b expected 0", imem_req); end
        @(negedge clk);
        branch_e = 1'b0;
        jump_d   = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL bj_addr got %h expected 00000200", imem_addr); end
        wait_valid(n);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'h200) begin failures++; $display("FAIL bj_first_pc got valid=%b pc=%h expected valid=1 pc=00000200", valid_d, pc_d); end
    endtask

    task automatic test_misalign();
`ifdef FETCH_MISALIGN_CHECK_EN
        logic req_seen;
`else
        int   n;
`endif
        do_reset();
        imem_gnt = 1'b1;
        repeat (2) @(negedge clk);
        branch_e    = 1'b1;
        pc_target_e = 32'h202;
        @(negedge clk);
        branch_e = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++; if (misaligned_f !== 1'b1) begin failures++; $display("FAIL misalign_flag got %b expected 1", misaligned_f); end
        req_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0) req_seen = 1'b1;
        end
        checks++; if (req_seen !== 1'b0) begin failures++; $display("FAIL misalign_req got %b expected 0", req_seen); end
        do_reset();
        #1;
        checks++; if (misaligned_f !== 1'b0 || imem_req !== 1'b1) begin failures++; $display("FAIL misalign_clear got flag=%b req=%b expected flag=0 req=1", misaligned_f, imem_req); end
`else
        checks++; if (misaligned_f !== 1'b0) begin failures++; $display("FAIL misalign_flag got %b expected 0", misaligned_f); end
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL misalign_addr got %h expected 00000200", imem_addr); end
        wait_valid(n);
        checks++; if (valid_d !== 1'b1 || pc_d !== 32'h200) begin failures++; $display("FAIL misalign_pc got valid=%b pc=%h expected valid=1 pc=00000200", valid_d, pc_d); end
`endif
    endtask

    task automatic test_halted();
        logic req_seen;
        int   n;
        do_reset();
        lat      = 2;
        imem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        halted = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL halted_req got %b expected 0", imem_req); end
        req_seen = 1'b0;
        n = 0;
        while (valid_d !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            if (imem_req !== 1'b0) req_seen = 1'b1;
            n++;
        end
        checks++; if (valid_d !== 1'b1 || pc_d !== c_RESET_PC) begin failures++; $display("FAIL halted_load got valid=%b pc=%h expected valid=1 pc=%h", valid_d, pc_d, c_RESET_PC); end
        checks++; if (req_seen !== 1'b0) begin failures++; $display("FAIL halted_no_req got %b expected 0", req_seen); end
        @(negedge clk);
        halted = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        imem_gnt = 1'b1;
        repeat (2) @(negedge clk);
        jump_d   = 1'b1;
        pc_imm_d = 32'hFFFF_FFF8;
        @(negedge clk);
        jump_d = 1'b0;
        grant_log.delete();
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_addr got %h expected fffffff8", imem_addr); end
        n = 0;
        while (grant_log.size() < 3 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (grant_log.size() < 3) begin
            failures++; $display("FAIL wrap_grants got %0d grants expected at least 3", grant_log.size());
        end else if (grant_log[0] !== 32'hFFFF_FFF8 || grant_log[1] !== 32'hFFFF_FFFC || grant_log[2] !== 32'h0) begin
            failures++; $display("FAIL wrap_grants got %h %h %h expected fffffff8 fffffffc 00000000", grant_log[0], grant_log[1], grant_log[2]);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_outstanding();
        logic v_seen;
        int   n;
        do_reset();
        lat      = 50;
        imem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_gnt = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat   = 1;
        inject_req++;
        v_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (valid_d !== 1'b0) v_seen = 1'b1;
        end
        checks++; if (v_seen !== 1'b0) begin failures++; $display("FAIL late_rvalid got valid=%b expected 0", v_seen); end
        @(negedge clk);
        imem_gnt = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== c_RESET_PC) begin failures++; $display("FAIL late_first_fetch got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, c_RESET_PC); end
        wait_valid(n);
        checks++; if (valid_d !== 1'b1 || pc_d !== c_RESET_PC || instr_d !== mem_word(c_RESET_PC)) begin failures++; $display("FAIL late_first_instr got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h", valid_d, pc_d, instr_d, c_RESET_PC, mem_word(c_RESET_PC)); end
        repeat (4) @(negedge clk);
    endtask

    initial begin : main
        test_reset();
        test_back_to_back();
        test_stall();
        test_jump();
        test_branch_jump();
        test_misalign();
        test_halted();
        test_wrap();
        test_reset_outstanding();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
